// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing definitions.
// Holds the 640x480@60 timing constants used by both the sync pulse
// generator and the sync decoder, the lock FSM state type, the width of the
// col/row counters, and a saturating increment helper for those counters.
package vga_pkg;

  localparam int VGA_H_TOTAL         = 800;
  localparam int VGA_H_ACT_START     = 144;
  localparam int VGA_H_ACTIVE        = 640;
  localparam int VGA_V_TOTAL         = 525;
  localparam int VGA_V_ACT_START     = 35;
  localparam int VGA_V_ACTIVE        = 480;
  localparam bit VGA_SYNC_ACTIVE_LOW = 1'b1;
  localparam int VGA_LOCK_FRAMES     = 2;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_decoder_sync_edge_det.sv
// sync_edge_det: sync input front end.
// Optionally double-registers the raw sync (macro VGA_SYNC_DECODER_CDC_EN),
// normalises polarity so that 1 means "asserted", and pulses o_edge for one
// cycle on the cycle the sync becomes asserted.
// Ports:
//   clk, rst_n : pixel clock, asynchronous active-low reset
//   i_sync     : raw sync input
//   o_edge     : combinational assertion-edge pulse
module sync_edge_det #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_edge
);

  logic w_sync;
  logic w_asserted;
  logic r_q;

`ifdef VGA_SYNC_DECODER_CDC_EN
  logic r_meta;
  logic r_sync;

  // Synchronizer flops reset to the deasserted level so reset release does
  // not look like a sync assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= ACTIVE_LOW;
      r_sync <= ACTIVE_LOW;
    end else begin
      r_meta <= i_sync;
      r_sync <= r_meta;
    end
  end

  assign w_sync = r_sync;
`else
  assign w_sync = i_sync;
`endif

  assign w_asserted = ACTIVE_LOW ? ~w_sync : w_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_asserted;
    end
  end

  assign o_edge = w_asserted & ~r_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive side of the VGA timing interface.
// Recovers pixel column/row from HSYNC/VSYNC, measures line and frame
// length, and declares lock after LOCK_FRAMES consecutive nominal frames.
// Optional macro VGA_SYNC_DECODER_CDC_EN adds two-flop synchronizers on the
// sync inputs (all latencies +2 clocks).
// Ports:
//   clk, rst_n       : pixel clock, asynchronous active-low reset
//   i_hsync, i_vsync : sync inputs, polarity set by SYNC_ACTIVE_LOW
//   o_de, o_x, o_y   : active-video enable and pixel position (0 when idle)
//   o_locked         : timing locked
//   o_frame_start    : one-cycle pulse after each frame boundary
//   o_h_total        : last measured line length in clocks
//   o_v_total        : last measured frame length in lines
//   o_err            : one-cycle pulse on loss of lock
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL         = VGA_H_TOTAL,
  parameter int H_ACT_START     = VGA_H_ACT_START,
  parameter int H_ACTIVE        = VGA_H_ACTIVE,
  parameter int V_TOTAL         = VGA_V_TOTAL,
  parameter int V_ACT_START     = VGA_V_ACT_START,
  parameter int V_ACTIVE        = VGA_V_ACTIVE,
  parameter bit SYNC_ACTIVE_LOW = VGA_SYNC_ACTIVE_LOW,
  parameter int LOCK_FRAMES     = VGA_LOCK_FRAMES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_hsync,
  input  logic             i_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_locked,
  output logic             o_frame_start,
  output logic [CNT_W-1:0] o_h_total,
  output logic [CNT_W-1:0] o_v_total,
  output logic             o_err
);

  localparam logic [CNT_W:0]   L_H_TOTAL = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0]   L_V_TOTAL = (CNT_W+1)'(V_TOTAL);
  localparam logic [CNT_W-1:0] L_H_BEG   = CNT_W'(H_ACT_START);
  localparam logic [CNT_W:0]   L_H_END   = (CNT_W+1)'(H_ACT_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] L_V_BEG   = CNT_W'(V_ACT_START);
  localparam logic [CNT_W:0]   L_V_END   = (CNT_W+1)'(V_ACT_START + V_ACTIVE);
  localparam logic [2:0]       L_LOCK    = 3'(LOCK_FRAMES);

  logic w_h_edge;
  logic w_v_edge;

  sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sync (i_hsync),
    .o_edge (w_h_edge)
  );

  sync_edge_det #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sync (i_vsync),
    .o_edge (w_v_edge)
  );

  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic             r_v_pend;
  logic             r_line_bad;
  logic             r_seen_frame;
  logic [2:0]       r_good_cnt;
  lock_state_e      r_state;
  logic             r_locked;
  logic             r_frame_start;
  logic             r_err;
  logic [CNT_W-1:0] r_h_total;
  logic [CNT_W-1:0] r_v_total;
  logic             r_de;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;

  // Lengths are one bit wider so a saturated counter (1023 + 1) can never
  // alias to a nominal length.
  logic [CNT_W:0] w_col_len;
  logic [CNT_W:0] w_row_len;
  logic           w_col_sat;
  logic           w_line_bad_now;
  logic           w_boundary;
  logic           w_frame_good;
  logic           w_h_act;
  logic           w_v_act;

  assign w_col_len      = {1'b0, r_col} + 1'b1;
  assign w_row_len      = {1'b0, r_row} + 1'b1;
  // Fires once, on the cycle the column counter reaches its ceiling.
  assign w_col_sat      = ~w_h_edge & (r_col == CNT_NEAR);
  assign w_line_bad_now = w_h_edge & (w_col_len != L_H_TOTAL);
  // A vsync edge seen earlier in the line, or in this very cycle, closes the
  // frame on this hsync edge.
  assign w_boundary     = w_h_edge & (r_v_pend | w_v_edge);
  // The line ending at the boundary is part of the frame being judged.
  assign w_frame_good   = r_seen_frame & ~r_line_bad & ~w_line_bad_now &
                          (w_row_len == L_V_TOTAL);

  assign w_h_act = (r_col >= L_H_BEG) & ({1'b0, r_col} < L_H_END);
  assign w_v_act = (r_row >= L_V_BEG) & ({1'b0, r_row} < L_V_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_v_pend      <= 1'b0;
      r_line_bad    <= 1'b0;
      r_seen_frame  <= 1'b0;
      r_frame_start <= 1'b0;
      r_h_total     <= '0;
      r_v_total     <= '0;
    end else begin
      if (w_h_edge) begin
        r_col     <= '0;
        r_h_total <= w_col_len[CNT_W-1:0];
      end else begin
        r_col <= sat_inc(r_col);
      end

      r_frame_start <= w_boundary;

      if (w_boundary) begin
        r_row        <= '0;
        r_v_total    <= w_row_len[CNT_W-1:0];
        r_v_pend     <= 1'b0;
        r_line_bad   <= 1'b0;
        r_seen_frame <= 1'b1;
      end else begin
        if (w_h_edge) begin
          r_row <= sat_inc(r_row);
        end
        if (w_v_edge) begin
          r_v_pend <= 1'b1;
        end
        if (w_line_bad_now || w_col_sat) begin
          r_line_bad <= 1'b1;
        end
      end
    end
  end

  // Lock FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_SEARCH;
      r_locked   <= 1'b0;
      r_good_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_boundary) begin
            if (w_frame_good) begin
              r_good_cnt <= r_good_cnt + 1'b1;
              if (r_good_cnt + 1'b1 >= L_LOCK) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_line_bad_now || w_col_sat || (w_boundary && !w_frame_good)) begin
            r_err      <= 1'b1;
            r_good_cnt <= '0;
            r_state    <= ST_SEARCH;
            r_locked   <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: position and enable from the counters one clock back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
    end else begin
      r_de <= r_locked & w_h_act & w_v_act;
      r_x  <= (r_locked & w_h_act & w_v_act) ? r_col - L_H_BEG : '0;
      r_y  <= (r_locked & w_h_act & w_v_act) ? r_row - L_V_BEG : '0;
    end
  end

  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_locked      = r_locked;
  assign o_frame_start = r_frame_start;
  assign o_h_total     = r_h_total;
  assign o_v_total     = r_v_total;
  assign o_err         = r_err;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with a reduced timing (40 x 20 total) so that
// many frames fit in a short run. A behavioural model derives the expected
// outputs from elapsed time since the last hsync edge and a count of lines
// since the last frame boundary; a few literal expectations pin the model.
module tb_vga_sync_decoder;

  localparam int HT   = 40;
  localparam int HAS  = 8;
  localparam int HA   = 24;
  localparam int VT   = 20;
  localparam int VAS  = 4;
  localparam int VA   = 12;
  localparam int LF   = 2;
  localparam bit ALOW = 1'b1;
  localparam int SATV = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs;
  logic       vs;
  logic       o_de;
  logic [9:0] o_x;
  logic [9:0] o_y;
  logic       o_locked;
  logic       o_frame_start;
  logic [9:0] o_h_total;
  logic [9:0] o_v_total;
  logic       o_err;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACTIVE(VA),
    .SYNC_ACTIVE_LOW(ALOW), .LOCK_FRAMES(LF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_hsync       (hs),
    .i_vsync       (vs),
    .o_de          (o_de),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_locked      (o_locked),
    .o_frame_start (o_frame_start),
    .o_h_total     (o_h_total),
    .o_v_total     (o_v_total),
    .o_err         (o_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Observed-event counters used by the literal checks
  int fs_cnt, err_cnt, de_cnt, x_max, y_max, lock_fs;
  bit prev_locked;

  int hw = 4;  // hsync width in clocks
  int vw = 2;  // vsync width in lines

  // Model state
  int m_cnt, m_ref, m_row, m_good;
  bit m_hq, m_vq, m_vpend, m_bad, m_seen, m_locked;
  bit h_d1, h_d2, v_d1, v_d2;
  bit e_de, e_fs, e_err, e_locked;
  int e_x, e_y, e_ht, e_vt;

  function automatic void model_reset();
    m_cnt = 0; m_ref = 0; m_row = 0; m_good = 0;
    m_hq = 0; m_vq = 0; m_vpend = 0; m_bad = 0; m_seen = 0; m_locked = 0;
    h_d1 = 0; h_d2 = 0; v_d1 = 0; v_d2 = 0;
    e_de = 0; e_fs = 0; e_err = 0; e_locked = 0;
    e_x = 0; e_y = 0; e_ht = 0; e_vt = 0;
  endfunction

  function automatic void model_step();
    int col_p, len;
    bit ha, va, he, ve, sat, lbad, bnd, gf;
    // Column = clocks elapsed since the last hsync edge, capped.
    col_p = (m_cnt - m_ref > SATV) ? SATV : m_cnt - m_ref;
    e_de = m_locked && col_p >= HAS && col_p < HAS + HA &&
           m_row >= VAS && m_row < VAS + VA;
    e_x = e_de ? col_p - HAS : 0;
    e_y = e_de ? m_row - VAS : 0;
`ifdef VGA_SYNC_DECODER_CDC_EN
    ha = h_d2; va = v_d2;
    h_d2 = h_d1; v_d2 = v_d1;
    h_d1 = ALOW ? !hs : hs;
    v_d1 = ALOW ? !vs : vs;
`else
    ha = ALOW ? !hs : hs;
    va = ALOW ? !vs : vs;
`endif
    he = ha && !m_hq;
    ve = va && !m_vq;
    m_hq = ha; m_vq = va;
    m_cnt++;
    sat = !he && (col_p == SATV - 1);
    lbad = 0;
    if (he) begin
      len  = col_p + 1;
      e_ht = len % 1024;
      lbad = (len != HT);
      m_ref = m_cnt;
    end
    bnd = he && (m_vpend || ve);
    e_fs = bnd;
    e_err = 0;
    gf = 0;
    if (bnd) begin
      gf = m_seen && !m_bad && !lbad && (m_row + 1 == VT);
      e_vt = (m_row + 1) % 1024;
      m_row = 0; m_vpend = 0; m_bad = 0; m_seen = 1;
    end else begin
      if (he && m_row < SATV) m_row++;
      if (ve) m_vpend = 1;
      if (lbad || sat) m_bad = 1;
    end
    if (!m_locked) begin
      if (bnd) begin
        if (gf) begin
          m_good++;
          if (m_good >= LF) m_locked = 1;
        end else begin
          m_good = 0;
        end
      end
    end else if (lbad || sat || (bnd && !gf)) begin
      e_err = 1; m_good = 0; m_locked = 0;
    end
    e_locked = m_locked;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    fs_cnt = 0; err_cnt = 0; de_cnt = 0; x_max = -1; y_max = -1;
    lock_fs = -1; prev_locked = 0;
  endtask

  // Single compare process: model advanced on each edge / reset, DUT sampled 1 ns later.
  initial begin
    model_reset();
    clear_mon();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      if (chk_en) begin
        n_tests++;
        if (o_de !== e_de || o_x !== e_x[9:0] || o_y !== e_y[9:0] ||
            o_locked !== e_locked || o_frame_start !== e_fs ||
            o_h_total !== e_ht[9:0] || o_v_total !== e_vt[9:0] || o_err !== e_err) begin
          n_fail++;
          $display("FAIL cycle_cmp t=%0t: got de=%0b x=%0d y=%0d lk=%0b fs=%0b ht=%0d vt=%0d err=%0b, expected de=%0b x=%0d y=%0d lk=%0b fs=%0b ht=%0d vt=%0d err=%0b",
                   $time, o_de, o_x, o_y, o_locked, o_frame_start, o_h_total, o_v_total, o_err,
                   e_de, e_x, e_y, e_locked, e_fs, e_ht, e_vt, e_err);
        end
      end
      if (o_frame_start === 1'b1) fs_cnt++;
      if (o_err === 1'b1) err_cnt++;
      if (o_de === 1'b1) begin
        de_cnt++;
        if (int'(o_x) > x_max) x_max = int'(o_x);
        if (int'(o_y) > y_max) y_max = int'(o_y);
      end
      if (o_locked === 1'b1 && !prev_locked) lock_fs = fs_cnt;
      prev_locked = (o_locked === 1'b1);
    end
  end

  task automatic tick(input bit h, input bit v);
    @(negedge clk);
    hs = ALOW ? !h : h;
    vs = ALOW ? !v : v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  // Lines first..nl-1 of a frame; line bl gets HT+bd clocks; vcol>0 starts
  // vsync mid-line at that column instead of together with hsync.
  task automatic frame(input int first, input int nl, input int bl, input int bd, input int vcol);
    for (int l = first; l < nl; l++) begin
      int len;
      len = (l == bl) ? HT + bd : HT;
      for (int c = 0; c < len; c++) begin
        bit v;
        if (vcol == 0) v = (l < vw);
        else v = (l == 0 && c >= vcol) || (l > 0 && l < vw) || (l == vw && c < vcol);
        tick(c < hw, v);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_de"}, o_de, 0);
    check({tag, "_x"}, o_x, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_locked"}, o_locked, 0);
    check({tag, "_fs"}, o_frame_start, 0);
    check({tag, "_htot"}, o_h_total, 0);
    check({tag, "_vtot"}, o_v_total, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    int e0, f0, kind;
    hs = ALOW; vs = ALOW;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;
    clear_mon();

    // Partial frame then nominal frames: lock at the 3rd boundary
    frame(10, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    de_cnt = 0; x_max = -1; y_max = -1;
    frame(0, VT, -1, 0, 0);
    check("lock_at_boundary", lock_fs, 3);
    check("locked", o_locked, 1);
    check("de_per_frame", de_cnt, HA * VA);
    check("x_max", x_max, HA - 1);
    check("y_max", y_max, VA - 1);
    check("h_total", o_h_total, HT);
    check("v_total", o_v_total, VT);

    // Short line while locked
    frame(0, VT, -1, 0, 0);
    e0 = err_cnt;
    frame(0, VT, 7, -1, 0);
    check("short_line_err", err_cnt - e0, 1);
    check("short_line_unlock", o_locked, 0);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    check("relock_after_short", o_locked, 1);

    // Short frame
    e0 = err_cnt;
    frame(0, VT - 1, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    check("short_frame_vtot", o_v_total, VT - 1);
    check("short_frame_unlock", o_locked, 0);
    check("short_frame_err", err_cnt - e0, 1);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    check("relock_after_frame", o_locked, 1);

    // hsync idle long enough to saturate the column counter
    e0 = err_cnt;
    idle(1100);
    check("sat_err", err_cnt - e0, 1);
    check("sat_unlock", o_locked, 0);
    check("sat_de", o_de, 0);
    tick(1'b1, 1'b0);
    idle(2);
    check("sat_htot_wrap", o_h_total, 0);

    // Relock, then vsync mid-line versus together with hsync
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    f0 = fs_cnt;
    for (int i = 0; i < 3; i++) frame(0, VT, -1, 0, 17);
    check("fs_midline_count", fs_cnt - f0, 3);
    f0 = fs_cnt;
    for (int i = 0; i < 3; i++) frame(0, VT, -1, 0, 0);
    check("fs_aligned_count", fs_cnt - f0, 3);

    // Asynchronous reset mid-frame
    frame(0, 10, -1, 0, 0);
    for (int c = 0; c < 17; c++) tick(c < hw, 1'b0);
    #1 check("pre_reset_de", o_de, 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    idle(3);
    #3 rst_n = 1'b1;
    clear_mon();
    frame(11, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    frame(0, VT, -1, 0, 0);
    check("relock_after_reset", lock_fs, 3);

    // Randomized frames with defects
    for (int i = 0; i < 24; i++) begin
      hw = $urandom_range(1, 6);
      vw = $urandom_range(1, 3);
      kind = $urandom_range(0, 9);
      case (kind)
        0: frame(0, VT, $urandom_range(0, VT - 1), -1, 0);
        1: frame(0, VT, $urandom_range(0, VT - 1), 1, 0);
        2: frame(0, VT - 1, -1, 0, 0);
        3: frame(0, VT + 1, -1, 0, 0);
        4: frame(0, VT, -1, 0, $urandom_range(1, HT - 1));
        5: begin idle($urandom_range(0, 50)); frame(0, VT, -1, 0, 0); end
        default: frame(0, VT, -1, 0, 0);
      endcase
    end
    hw = 4; vw = 2;
    idle(4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
